muldiv_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler with HI/LO registers, sitting in the E stage beside the ALU.
- Accepts one mult/multu/div/divu/mthi/mtlo per issue and models the fixed operation latency with a busy counter.
- Drives a stall request to the hazard unit so that a D-stage HI/LO-using instruction waits while an operation is starting or in flight.
- Exposes HI and LO to the W-result mux for mfhi and mflo.

---
 rtl/muldiv_sched_pkg.sv | 20 ++
 rtl/muldiv_sched_md_arith.sv | 57 +++++
 rtl/muldiv_sched.sv | 104 ++++++++++
 tb/tb_muldiv_sched.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the E-stage multiply/divide scheduler:
// operation encodings, default latencies and FSM states.
package muldiv_sched_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/muldiv_sched_md_arith.sv
// Combinational multiply/divide datapath producing {HI,LO} and a
// divide-by-zero flag.
module md_arith
    import muldiv_sched_pkg::*;
(
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div0
);

    logic               w_b_zero;
    logic               w_ovf;
    logic [31:0]        w_sdivisor;
    logic [31:0]        w_udivisor;
    logic signed [63:0] w_sprod;
    logic [63:0]        w_uprod;
    logic signed [31:0] w_squot;
    logic signed [31:0] w_srem;
    logic [31:0]        w_uquot;
    logic [31:0]        w_urem;

    assign w_b_zero = (b == 32'd0);
    assign w_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // A divisor of 1 keeps the divider defined for x/0 and makes the
    // signed overflow case yield quotient=a, remainder=0 naturally.
    assign w_sdivisor = (w_b_zero || w_ovf) ? 32'd1 : b;
    assign w_udivisor = w_b_zero ? 32'd1 : b;

    assign w_sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_uprod = {32'd0, a} * {32'd0, b};
    assign w_squot = $signed(a) / $signed(w_sdivisor);
    assign w_srem  = $signed(a) % $signed(w_sdivisor);
    assign w_uquot = a / w_udivisor;
    assign w_urem  = a % w_udivisor;

    always_comb begin
        result = 64'd0;
        div0   = 1'b0;
        case (mdop)
            MD_MULT:  result = w_sprod;
            MD_MULTU: result = w_uprod;
            MD_DIV: begin
                result = {w_srem, w_squot};
                div0   = w_b_zero;
            end
            MD_DIVU: begin
                result = {w_urem, w_uquot};
                div0   = w_b_zero;
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/muldiv_sched.sv
// Multi-cycle mult/div scheduler: latches the result at issue, holds busy
// for the fixed latency, then commits to HI/LO.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_E,
    input  logic [2:0]  mdop_E,
    input  logic [31:0] srca_E,
    input  logic [31:0] srcb_E,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_div0;
    logic [63:0]        w_result;
    logic               w_div0;

    md_arith u_md_arith (
        .mdop   (mdop_E),
        .a      (srca_E),
        .b      (srcb_E),
        .result (w_result),
        .div0   (w_div0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_pend_div0 <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_E) begin
                        case (mdop_E)
                            MD_MULT, MD_MULTU: begin
                                r_pend_hi   <= w_result[63:32];
                                r_pend_lo   <= w_result[31:0];
                                r_pend_div0 <= 1'b0;
                                r_cnt       <= CNT_W'(MULT_CYCLES - 1);
                                r_state     <= ST_BUSY;
                                r_busy      <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_pend_hi   <= w_result[63:32];
                                r_pend_lo   <= w_result[31:0];
                                r_pend_div0 <= w_div0;
                                r_cnt       <= CNT_W'(DIV_CYCLES - 1);
                                r_state     <= ST_BUSY;
                                r_busy      <= 1'b1;
                            end
                            MD_MTHI: r_hi <= srca_E;
                            MD_MTLO: r_lo <= srca_E;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // Issues arriving here are dropped; HI/LO only change at completion.
                    if (r_cnt == '0) begin
                        if (!r_pend_div0) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign stall_md = (start_E | r_busy) & md_use_D;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: latency, HI/LO results, stall and reset.
module tb_muldiv_sched;

    logic        clk;
    logic        reset;
    logic        start_E;
    logic [2:0]  mdop_E;
    logic [31:0] srca_E;
    logic [31:0] srcb_E;
    logic        md_use_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    muldiv_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_E  (start_E),
        .mdop_E   (mdop_E),
        .srca_E   (srca_E),
        .srcb_E   (srcb_E),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one MD op; optionally pulse an illegal start_E at busy cycle 2.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_d, input int exp_n,
                          input logic [31:0] new_hi, input logic [31:0] new_lo,
                          input logic inject);
        int n;
        start_E  = 1'b1;
        mdop_E   = op;
        srca_E   = a;
        srcb_E   = b;
        md_use_D = use_d;
        #1;
        chk({tag, ".stall_issue"}, {63'd0, stall_md}, {63'd0, use_d});
        tick();
        start_E = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (inject && n == 2) begin
                start_E = 1'b1;
                mdop_E  = 3'd2;
                srca_E  = 32'd100;
                srcb_E  = 32'd7;
            end
            #1;
            chk({tag, ".hi_hold"}, {32'd0, hi}, {32'd0, exp_hi});
            chk({tag, ".lo_hold"}, {32'd0, lo}, {32'd0, exp_lo});
            chk({tag, ".stall_busy"}, {63'd0, stall_md}, {63'd0, use_d});
            n++;
            tick();
            start_E = 1'b0;
        end
        chk({tag, ".busy_cycles"}, 64'(n), 64'(exp_n));
        exp_hi = new_hi;
        exp_lo = new_lo;
        chk({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
        chk({tag, ".stall_done"}, {63'd0, stall_md}, 64'd0);
        $display("op %s mdop=%0d a=0x%08h b=0x%08h busy_cycles=%0d hi=0x%08h lo=0x%08h",
                 tag, op, a, b, n, hi, lo);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
        start_E  = 1'b1;
        mdop_E   = op;
        srca_E   = a;
        srcb_E   = 32'd0;
        md_use_D = 1'b0;
        tick();
        start_E = 1'b0;
        if (op == 3'd4) exp_hi = a;
        else            exp_lo = a;
        chk({tag, ".busy"}, {63'd0, busy}, 64'd0);
        chk({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_lo});
        $display("op %s mdop=%0d a=0x%08h hi=0x%08h lo=0x%08h", tag, op, a, hi, lo);
    endtask

    initial begin
        reset    = 1'b1;
        start_E  = 1'b0;
        mdop_E   = 3'd0;
        srca_E   = 32'd0;
        srcb_E   = 32'd0;
        md_use_D = 1'b0;
        tick();
        tick();
        chk("reset.busy", {63'd0, busy}, 64'd0);
        chk("reset.hi", {32'd0, hi}, 64'd0);
        chk("reset.lo", {32'd0, lo}, 64'd0);
        chk("reset.stall", {63'd0, stall_md}, 64'd0);
        reset = 1'b0;
        tick();

        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_mt("mthi", 3'd4, 32'h11);
        run_mt("mtlo", 3'd5, 32'h22);
        run_op("divu_zero", 3'd3, 32'd9, 32'd0, 1'b0, 10, 32'h11, 32'h22, 1'b0);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0, 32'h8000_0000, 1'b0);
        run_mt("mtlo_dead", 3'd5, 32'hDEAD);
        run_op("mult_inject", 3'd0, 32'd3, 32'd4, 1'b1, 5, 32'd0, 32'd12, 1'b1);
        // Issued the same cycle busy fell from the previous op.
        run_op("divu_b2b", 3'd3, 32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14, 1'b0);

        start_E  = 1'b1;
        mdop_E   = 3'd2;
        srca_E   = 32'd50;
        srcb_E   = 32'd3;
        md_use_D = 1'b0;
        tick();
        start_E = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_mid.busy_before", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid.busy", {63'd0, busy}, 64'd0);
        chk("rst_mid.hi", {32'd0, hi}, 64'd0);
        chk("rst_mid.lo", {32'd0, lo}, 64'd0);
        $display("op reset_mid_div busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        tick();
        reset = 1'b0;
        tick();
        run_op("mult_after_rst", 3'd0, 32'd6, 32'd7, 1'b1, 5, 32'd0, 32'd42, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
